// File: rtl/mem_stage_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_pkg
//   Shared definitions for the memory-stage controller:
//   - default datapath / SRAM widths and wait-state count
//   - MEM_* FSM state encodings (2 bits)
//   - EX_* memory command encodings and the decode helper that applies
//     write-over-read priority when both enables are set
// -----------------------------------------------------------------------------
package mem_stage_ctrl_pkg;

  localparam int DEF_SRAM_ADDR_WIDTH = 18;
  localparam int DEF_SRAM_DATA_WIDTH = 16;
  localparam int DEF_WORD_WIDTH      = 2 * DEF_SRAM_DATA_WIDTH;
  localparam int DEF_WAIT_CYCLES     = 1;

  // Wide enough for the full 0..7 wait-state range.
  localparam int CNT_WIDTH = 3;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_LO   = 2'd1,
    MEM_HI   = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_e;

  typedef enum logic [1:0] {
    EX_NONE = 2'd0,
    EX_LDR  = 2'd1,
    EX_STR  = 2'd2
  } mem_cmd_e;

  // A store wins when both enables are high; the load is dropped.
  function automatic mem_cmd_e decode_cmd(input logic r_en, input logic w_en);
    mem_cmd_e cmd;
    if (w_en)      cmd = EX_STR;
    else if (r_en) cmd = EX_LDR;
    else           cmd = EX_NONE;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_if
//   External 16-bit SRAM bus as seen by the memory-stage controller.
//   master: controller side (drives address, write data, strobes)
//   slave : SRAM side (returns read data)
//   Signals:
//     sram_addr   half-word address
//     sram_wdata  write half-word
//     sram_rdata  read half-word
//     sram_we_n   write enable, active low
//     sram_oe_n   output enable, active low
// -----------------------------------------------------------------------------
interface mem_stage_ctrl_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;
  logic                  sram_we_n;
  logic                  sram_oe_n;

  modport master (
    output sram_addr, sram_wdata, sram_we_n, sram_oe_n,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr, sram_wdata, sram_we_n, sram_oe_n,
    output sram_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl_sram_beat_timer.sv
// -----------------------------------------------------------------------------
// sram_beat_timer
//   Wait-state counter for one SRAM half-word beat. While run is high the
//   counter advances once per cycle; beat_done pulses on the cycle where the
//   count reaches WAIT_CYCLES, and the counter clears so the next beat starts
//   from zero.
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     run        a beat is in progress
//     beat_done  last cycle of the current beat
// -----------------------------------------------------------------------------
module sram_beat_timer
  import mem_stage_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic beat_done
);

  cnt_t cnt_reg;

  assign beat_done = run && (cnt_reg == cnt_t'(WAIT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (!run || beat_done) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + cnt_t'(1);
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//   Memory-stage access controller. Takes the ALU result as a byte address and
//   performs a 32-bit LDR/STR against a 16-bit SRAM as two half-word beats
//   (low half first), each beat held for WAIT_CYCLES+1 cycles. freeze stalls
//   the pipeline until the access finishes; the loaded word is registered on
//   mem_rdata and stays there until the next load overwrites it.
//   Ports:
//     clk, rst_n          clock / asynchronous active-low reset
//     mem_r_en, mem_w_en  LDR / STR request (store wins if both set)
//     alu_res             byte address (bits [1:0] and above the SRAM ignored)
//     st_val              store data
//     mem_rdata           loaded word, registered
//     freeze              pipeline stall
//     sram                SRAM bus (master side)
// -----------------------------------------------------------------------------
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH      = DEF_WORD_WIDTH,
  parameter int SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH,
  parameter int SRAM_DATA_WIDTH = DEF_SRAM_DATA_WIDTH,
  parameter int WAIT_CYCLES     = DEF_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic [WORD_WIDTH-1:0] alu_res,
  input  logic [WORD_WIDTH-1:0] st_val,
  output logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  freeze,
  mem_stage_ctrl_if.master      sram
);

  mem_state_e state_reg;
  logic       op_write_reg;
  mem_cmd_e   cmd;
  logic       req;
  logic       beat_run;
  logic       beat_done;
  logic       unused_addr_bits;

  assign cmd      = decode_cmd(mem_r_en, mem_w_en);
  assign req      = (cmd != EX_NONE);
  assign beat_run = (state_reg == MEM_LO) || (state_reg == MEM_HI);

  // Byte-lane bits and bits beyond the SRAM size do not take part in the
  // address; the access wraps modulo the SRAM size.
  assign unused_addr_bits = ^{alu_res[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1], alu_res[1:0]};

  sram_beat_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_beat_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (beat_run),
    .beat_done (beat_done)
  );

  // Access sequencer. The operation type is latched when the access starts
  // so both beats agree even if the request lines wobble mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= MEM_IDLE;
      op_write_reg <= 1'b0;
      mem_rdata    <= '0;
    end else begin
      case (state_reg)
        MEM_IDLE: begin
          if (req) begin
            state_reg    <= MEM_LO;
            op_write_reg <= (cmd == EX_STR);
          end
        end
        MEM_LO: begin
          if (beat_done) begin
            if (!op_write_reg) mem_rdata[SRAM_DATA_WIDTH-1:0] <= sram.sram_rdata;
            state_reg <= MEM_HI;
          end
        end
        MEM_HI: begin
          if (beat_done) begin
            if (!op_write_reg) mem_rdata[WORD_WIDTH-1:SRAM_DATA_WIDTH] <= sram.sram_rdata;
            state_reg <= MEM_DONE;
          end
        end
        default: begin
          // DONE: the pipeline advances this cycle; a following memory
          // instruction is seen in the next IDLE cycle.
          state_reg <= MEM_IDLE;
        end
      endcase
    end
  end

  // SRAM strobes and stall decoded from the state register plus the held
  // EX/MEM inputs. IDLE and DONE park the bus, so every write beat pair is
  // bracketed by we_n high.
  always_comb begin
    sram.sram_addr  = '0;
    sram.sram_wdata = '0;
    sram.sram_we_n  = 1'b1;
    sram.sram_oe_n  = 1'b1;
    freeze          = 1'b0;
    case (state_reg)
      MEM_IDLE: begin
        freeze = req;
      end
      MEM_LO, MEM_HI: begin
        freeze         = 1'b1;
        sram.sram_addr = {alu_res[SRAM_ADDR_WIDTH:2], (state_reg == MEM_HI)};
        if (op_write_reg) begin
          sram.sram_we_n  = 1'b0;
          sram.sram_wdata = (state_reg == MEM_HI) ? st_val[WORD_WIDTH-1:SRAM_DATA_WIDTH]
                                                  : st_val[SRAM_DATA_WIDTH-1:0];
        end else begin
          sram.sram_oe_n = 1'b0;
        end
      end
      default: begin
        freeze = 1'b0;
      end
    endcase
    // The stall must not leak out while the block is held in reset.
    if (!rst_n) freeze = 1'b0;
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
//   Directed bench for mem_stage_ctrl. dut1 runs with WAIT_CYCLES=1, dut0 with
//   WAIT_CYCLES=0; each has its own behavioural SRAM (combinational read,
//   write on rising edge while we_n is low). Inputs change on the falling
//   edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic        r_en1, w_en1, freeze1;
  logic [31:0] alu1, st1, rdata1;
  logic        r_en0, w_en0, freeze0;
  logic [31:0] alu0, st0, rdata0;

  mem_stage_ctrl_if #(.ADDR_WIDTH(18), .DATA_WIDTH(16)) sram1 ();
  mem_stage_ctrl_if #(.ADDR_WIDTH(18), .DATA_WIDTH(16)) sram0 ();

  mem_stage_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_r_en(r_en1), .mem_w_en(w_en1),
    .alu_res(alu1), .st_val(st1), .mem_rdata(rdata1), .freeze(freeze1),
    .sram(sram1.master)
  );

  mem_stage_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_r_en(r_en0), .mem_w_en(w_en0),
    .alu_res(alu0), .st_val(st0), .mem_rdata(rdata0), .freeze(freeze0),
    .sram(sram0.master)
  );

  logic [15:0] mem1 [0:(1<<18)-1];
  logic [15:0] mem0 [0:(1<<18)-1];

  assign sram1.sram_rdata = mem1[sram1.sram_addr];
  assign sram0.sram_rdata = mem0[sram0.sram_addr];

  always @(posedge clk) if (!sram1.sram_we_n) mem1[sram1.sram_addr] <= sram1.sram_wdata;
  always @(posedge clk) if (!sram0.sram_we_n) mem0[sram0.sram_addr] <= sram0.sram_wdata;

  // Called while rst_n is low: everything at reset values, freeze held low
  // even with a store request present.
  task automatic test_reset();
    w_en1 = 1'b1; alu1 = 32'h104; st1 = 32'h1;
    #1;
    checks++; if (freeze1 !== 1'b0) $display("FAIL reset_freeze: got %b want 0", freeze1); else passed++;
    checks++; if ({sram1.sram_we_n, sram1.sram_oe_n} !== 2'b11) $display("FAIL reset_strobes: got %b want 11", {sram1.sram_we_n, sram1.sram_oe_n}); else passed++;
    checks++; if (sram1.sram_addr !== 18'h0 || sram1.sram_wdata !== 16'h0) $display("FAIL reset_bus: addr %h wdata %h want 0 0", sram1.sram_addr, sram1.sram_wdata); else passed++;
    checks++; if (rdata1 !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata1); else passed++;
    checks++; if (dut1.state_reg !== MEM_IDLE) $display("FAIL reset_state: got %0d want IDLE", dut1.state_reg); else passed++;
    checks++; if (freeze0 !== 1'b0 || rdata0 !== 32'h0 || sram0.sram_we_n !== 1'b1) $display("FAIL reset_dut0: freeze %b rdata %h we_n %b", freeze0, rdata0, sram0.sram_we_n); else passed++;
    w_en1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: initial reset state checked");
  endtask

  // Store to byte 0x200 (half-words 0x100/0x101), reset pulled in the HI beat.
  task automatic test_reset_mid_access();
    w_en1 = 1'b1; alu1 = 32'h0000_0200; st1 = 32'h1234_5678;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (sram1.sram_addr !== 18'h101 || sram1.sram_wdata !== 16'h1234 || sram1.sram_we_n !== 1'b0) $display("FAIL midreset_hi: addr %h wdata %h we_n %b want 101 1234 0", sram1.sram_addr, sram1.sram_wdata, sram1.sram_we_n); else passed++;
    #1; rst_n = 1'b0; #1;
    checks++; if (freeze1 !== 1'b0) $display("FAIL midreset_freeze: got %b want 0", freeze1); else passed++;
    checks++; if ({sram1.sram_we_n, sram1.sram_oe_n} !== 2'b11) $display("FAIL midreset_strobes: got %b want 11", {sram1.sram_we_n, sram1.sram_oe_n}); else passed++;
    checks++; if (sram1.sram_addr !== 18'h0 || sram1.sram_wdata !== 16'h0) $display("FAIL midreset_bus: addr %h wdata %h want 0 0", sram1.sram_addr, sram1.sram_wdata); else passed++;
    checks++; if (dut1.state_reg !== MEM_IDLE || rdata1 !== 32'h0) $display("FAIL midreset_state: state %0d rdata %h want IDLE 0", dut1.state_reg, rdata1); else passed++;
    checks++; if (mem1[18'h100] !== 16'h5678) $display("FAIL midreset_partial: mem[100] %h want 5678", mem1[18'h100]); else passed++;
    w_en1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({freeze1, sram1.sram_we_n, sram1.sram_oe_n} !== 3'b011) $display("FAIL post_reset_idle c%0d: freeze/we_n/oe_n %b want 011", c, {freeze1, sram1.sram_we_n, sram1.sram_oe_n}); else passed++;
      @(negedge clk);
    end
    $display("reset: write aborted in HI beat, idle after release");
  endtask

  // STR 0xDEADBEEF to byte 0x104 -> half-words 0x082 (low) / 0x083 (high).
  task automatic test_store();
    int fcnt = 0;
    logic [17:0] ea;
    logic [15:0] ed;
    w_en1 = 1'b1; alu1 = 32'h0000_0104; st1 = 32'hDEAD_BEEF;
    for (int c = 0; c < 6; c++) begin
      #1;
      ea = (c == 1 || c == 2) ? 18'h082 : (c == 3 || c == 4) ? 18'h083 : 18'h0;
      ed = (c == 1 || c == 2) ? 16'hBEEF : (c == 3 || c == 4) ? 16'hDEAD : 16'h0;
      if (freeze1 === 1'b1) fcnt++;
      checks++; if (freeze1 !== (c < 5)) $display("FAIL str_freeze c%0d: got %b want %b", c, freeze1, (c < 5)); else passed++;
      checks++; if (sram1.sram_we_n !== !(c >= 1 && c <= 4)) $display("FAIL str_we_n c%0d: got %b want %b", c, sram1.sram_we_n, !(c >= 1 && c <= 4)); else passed++;
      checks++; if (sram1.sram_oe_n !== 1'b1) $display("FAIL str_oe_n c%0d: got %b want 1", c, sram1.sram_oe_n); else passed++;
      checks++; if (sram1.sram_addr !== ea || sram1.sram_wdata !== ed) $display("FAIL str_bus c%0d: addr %h wdata %h want %h %h", c, sram1.sram_addr, sram1.sram_wdata, ea, ed); else passed++;
      @(negedge clk);
    end
    w_en1 = 1'b0;
    checks++; if (fcnt != 5) $display("FAIL str_stall_len: got %0d want 5", fcnt); else passed++;
    checks++; if (mem1[18'h082] !== 16'hBEEF || mem1[18'h083] !== 16'hDEAD) $display("FAIL str_sram: %h %h want BEEF DEAD", mem1[18'h082], mem1[18'h083]); else passed++;
    $display("STR  addr=%h data=%h wait=1", 32'h104, 32'hDEADBEEF);
  endtask

  // LDR from byte 0x104; low half visible after the LO beat, full word in DONE.
  task automatic test_load();
    logic [31:0] er;
    r_en1 = 1'b1; alu1 = 32'h0000_0104; st1 = 32'h0;
    for (int c = 0; c < 6; c++) begin
      #1;
      er = (c == 5) ? 32'hDEAD_BEEF : (c >= 3) ? 32'h0000_BEEF : 32'h0;
      checks++; if (freeze1 !== (c < 5)) $display("FAIL ldr_freeze c%0d: got %b want %b", c, freeze1, (c < 5)); else passed++;
      checks++; if (sram1.sram_oe_n !== !(c >= 1 && c <= 4)) $display("FAIL ldr_oe_n c%0d: got %b want %b", c, sram1.sram_oe_n, !(c >= 1 && c <= 4)); else passed++;
      checks++; if (sram1.sram_we_n !== 1'b1) $display("FAIL ldr_we_n c%0d: got %b want 1", c, sram1.sram_we_n); else passed++;
      checks++; if (rdata1 !== er) $display("FAIL ldr_rdata c%0d: got %h want %h", c, rdata1, er); else passed++;
      @(negedge clk);
    end
    r_en1 = 1'b0;
    $display("LDR  addr=%h data=%h wait=1", 32'h104, rdata1);
  endtask

  // Both enables high at byte 0x8: a store to half-words 0x4/0x5, no read.
  task automatic test_both_enables();
    logic [17:0] ea;
    r_en1 = 1'b1; w_en1 = 1'b1; alu1 = 32'h0000_0008; st1 = 32'hCAFE_F00D;
    for (int c = 0; c < 6; c++) begin
      #1;
      ea = (c == 1 || c == 2) ? 18'h004 : (c == 3 || c == 4) ? 18'h005 : 18'h0;
      checks++; if (sram1.sram_we_n !== !(c >= 1 && c <= 4)) $display("FAIL both_we_n c%0d: got %b want %b", c, sram1.sram_we_n, !(c >= 1 && c <= 4)); else passed++;
      checks++; if (sram1.sram_oe_n !== 1'b1) $display("FAIL both_oe_n c%0d: got %b want 1", c, sram1.sram_oe_n); else passed++;
      checks++; if (sram1.sram_addr !== ea) $display("FAIL both_addr c%0d: got %h want %h", c, sram1.sram_addr, ea); else passed++;
      checks++; if (rdata1 !== 32'hDEAD_BEEF) $display("FAIL both_rdata c%0d: got %h want DEADBEEF", c, rdata1); else passed++;
      @(negedge clk);
    end
    r_en1 = 1'b0; w_en1 = 1'b0;
    checks++; if (mem1[18'h004] !== 16'hF00D || mem1[18'h005] !== 16'hCAFE) $display("FAIL both_sram: %h %h want F00D CAFE", mem1[18'h004], mem1[18'h005]); else passed++;
    $display("R+W  addr=%h data=%h treated as store", 32'h8, 32'hCAFEF00D);
  endtask

  // Ten non-memory cycles with changing operands: bus parked, word held.
  task automatic test_non_mem();
    for (int c = 0; c < 10; c++) begin
      alu1 = 32'h1000 * c + 32'h4; st1 = $urandom;
      #1;
      checks++; if ({freeze1, sram1.sram_we_n, sram1.sram_oe_n} !== 3'b011) $display("FAIL nop_bus c%0d: freeze/we_n/oe_n %b want 011", c, {freeze1, sram1.sram_we_n, sram1.sram_oe_n}); else passed++;
      checks++; if (rdata1 !== 32'hDEAD_BEEF) $display("FAIL nop_rdata c%0d: got %h want DEADBEEF", c, rdata1); else passed++;
      @(negedge clk);
    end
    $display("NOP  10 cycles, mem_rdata=%h", rdata1);
  endtask

  // WAIT_CYCLES=0: LDR byte 0x20 (half-words 0x10/0x11), then in the very
  // next IDLE cycle STR to 0xFFF80027, which wraps to half-words 0x12/0x13.
  task automatic test_back_to_back();
    logic [7:0]  efz = 8'b0111_0111;
    logic [7:0]  ewe = 8'b1001_1111;
    logic [7:0]  eoe = 8'b1111_1001;
    logic [17:0] ea [8] = '{18'h0, 18'h10, 18'h11, 18'h0, 18'h0, 18'h12, 18'h13, 18'h0};
    logic [31:0] er [8] = '{32'h0, 32'h0, 32'h3344, 32'h1122_3344, 32'h1122_3344,
                            32'h1122_3344, 32'h1122_3344, 32'h1122_3344};
    mem0[18'h10] = 16'h3344; mem0[18'h11] = 16'h1122;
    r_en0 = 1'b1; alu0 = 32'h0000_0020; st0 = 32'h0;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) begin
        r_en0 = 1'b0; w_en0 = 1'b1; alu0 = 32'hFFF8_0027; st0 = 32'hA5A5_5A5A;
      end
      #1;
      checks++; if (freeze0 !== efz[c]) $display("FAIL b2b_freeze c%0d: got %b want %b", c, freeze0, efz[c]); else passed++;
      checks++; if ({sram0.sram_we_n, sram0.sram_oe_n} !== {ewe[c], eoe[c]}) $display("FAIL b2b_strobes c%0d: we_n/oe_n %b want %b", c, {sram0.sram_we_n, sram0.sram_oe_n}, {ewe[c], eoe[c]}); else passed++;
      checks++; if (sram0.sram_addr !== ea[c]) $display("FAIL b2b_addr c%0d: got %h want %h", c, sram0.sram_addr, ea[c]); else passed++;
      checks++; if (rdata0 !== er[c]) $display("FAIL b2b_rdata c%0d: got %h want %h", c, rdata0, er[c]); else passed++;
      if (c == 5 || c == 6) begin
        checks++; if (sram0.sram_wdata !== ((c == 5) ? 16'h5A5A : 16'hA5A5)) $display("FAIL b2b_wdata c%0d: got %h want %h", c, sram0.sram_wdata, (c == 5) ? 16'h5A5A : 16'hA5A5); else passed++;
      end
      @(negedge clk);
    end
    w_en0 = 1'b0;
    checks++; if (mem0[18'h12] !== 16'h5A5A || mem0[18'h13] !== 16'hA5A5) $display("FAIL b2b_sram: %h %h want 5A5A A5A5", mem0[18'h12], mem0[18'h13]); else passed++;
    $display("LDR  addr=%h data=%h wait=0", 32'h20, 32'h11223344);
    $display("STR  addr=%h data=%h wait=0 (back-to-back)", 32'hFFF80027, 32'hA5A55A5A);
  endtask

  initial begin
    rst_n = 1'b0;
    r_en1 = 1'b0; w_en1 = 1'b0; alu1 = '0; st1 = '0;
    r_en0 = 1'b0; w_en0 = 1'b0; alu0 = '0; st0 = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_reset_mid_access();
    test_store();
    test_load();
    test_both_enables();
    test_non_mem();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
